// File: rtl/imm_generator_pkg.sv
// Shared constants for the RV32I immediate generator: opcodes, shift funct3 codes, format codes.
// Build option IMM_ZICSR_EN adds CSR-immediate decoding of the SYSTEM opcode.
package imm_generator_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  localparam logic [2:0] IMM_FMT_R = 3'd0;
  localparam logic [2:0] IMM_FMT_I = 3'd1;
  localparam logic [2:0] IMM_FMT_S = 3'd2;
  localparam logic [2:0] IMM_FMT_B = 3'd3;
  localparam logic [2:0] IMM_FMT_U = 3'd4;
  localparam logic [2:0] IMM_FMT_J = 3'd5;
  localparam logic [2:0] IMM_FMT_Z = 3'd6;

endpackage

// File: rtl/imm_generator_imm_decode.sv
// Combinational RV32I immediate decode: instruction word -> extended immediate, format, unknown flag.
// Build option IMM_ZICSR_EN enables CSR-immediate decoding of SYSTEM instructions.
module imm_decode
  import imm_generator_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm,
  output logic [2:0]  fmt,
  output logic        unknown
);

  logic [6:0] w_opc;
  logic [2:0] w_f3;

  assign w_opc = instr[6:0];
  assign w_f3  = instr[14:12];

  always_comb begin
    imm     = '0;
    fmt     = IMM_FMT_R;
    unknown = 1'b0;
    case (w_opc)
      OPC_OP: begin
        fmt = IMM_FMT_R;
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        fmt = IMM_FMT_I;
        // Shift amounts are a 5-bit unsigned field, not a sign-extended immediate
        if (w_opc == OPC_OP_IMM && (w_f3 == F3_SLL || w_f3 == F3_SRL_SRA))
          imm = {27'd0, instr[24:20]};
        else
          imm = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        fmt = IMM_FMT_S;
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        fmt = IMM_FMT_B;
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt = IMM_FMT_U;
        imm = {instr[31:12], 12'd0};
      end
      OPC_JAL: begin
        fmt = IMM_FMT_J;
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_SYSTEM: begin
`ifdef IMM_ZICSR_EN
        if (w_f3 == 3'b101 || w_f3 == 3'b110 || w_f3 == 3'b111) begin
          fmt = IMM_FMT_Z;
          imm = {27'd0, instr[19:15]};
        end else begin
          fmt = IMM_FMT_I;
          imm = {{20{instr[31]}}, instr[31:20]};
        end
`else
        fmt = IMM_FMT_R;
`endif
      end
      OPC_FENCE: begin
        fmt = IMM_FMT_R;
      end
      default: begin
        unknown = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_generator.sv
// RV32I decode-stage immediate generator: registers the decoded immediate one cycle after instr_valid.
// Build option IMM_ZICSR_EN (handled in imm_decode) adds CSR-immediate support.
module imm_generator
  import imm_generator_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic [31:0] imm,
  output logic [2:0]  imm_fmt,
  output logic        imm_valid,
  output logic        unknown_op
);

  logic [31:0] w_imm;
  logic [2:0]  w_fmt;
  logic        w_unknown;

  logic [31:0] r_imm;
  logic [2:0]  r_fmt;
  logic        r_valid;
  logic        r_unknown;

  imm_decode u_decode (
    .instr   (instr),
    .imm     (w_imm),
    .fmt     (w_fmt),
    .unknown (w_unknown)
  );

  // Output stage: payload only updates on valid input, so it holds across bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_imm     <= '0;
      r_fmt     <= IMM_FMT_R;
      r_valid   <= 1'b0;
      r_unknown <= 1'b0;
    end else begin
      r_valid <= instr_valid;
      if (instr_valid) begin
        r_imm     <= w_imm;
        r_fmt     <= w_fmt;
        r_unknown <= w_unknown;
      end
    end
  end

  assign imm        = r_imm;
  assign imm_fmt    = r_fmt;
  assign imm_valid  = r_valid;
  assign unknown_op = r_unknown;

endmodule

// File: tb/tb_imm_generator.sv
// Directed testbench for imm_generator with hand-computed immediates and assertion-based checks.
// Expectations for the SYSTEM opcode follow the IMM_ZICSR_EN build option.
module tb_imm_generator;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] imm;
  logic [2:0]  imm_fmt;
  logic        imm_valid;
  logic        unknown_op;

  int n_assert;
  int n_fail;

  imm_generator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .imm         (imm),
    .imm_fmt     (imm_fmt),
    .imm_valid   (imm_valid),
    .unknown_op  (unknown_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply(input logic v, input logic [31:0] ins);
    instr_valid = v;
    instr       = ins;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] e_imm, input logic [2:0] e_fmt,
                     input logic e_vld, input logic e_unk);
    n_assert++;
    assert (imm === e_imm) else begin
      n_fail++;
      $error("FAIL %s imm: got %h expected %h", tag, imm, e_imm);
    end
    n_assert++;
    assert (imm_fmt === e_fmt) else begin
      n_fail++;
      $error("FAIL %s imm_fmt: got %0d expected %0d", tag, imm_fmt, e_fmt);
    end
    n_assert++;
    assert (imm_valid === e_vld) else begin
      n_fail++;
      $error("FAIL %s imm_valid: got %b expected %b", tag, imm_valid, e_vld);
    end
    n_assert++;
    assert (unknown_op === e_unk) else begin
      n_fail++;
      $error("FAIL %s unknown_op: got %b expected %b", tag, unknown_op, e_unk);
    end
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 32'h0, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    apply(1'b1, 32'h00410193); chk("addi_4",     32'h00000004, 3'd1, 1'b1, 1'b0);
    apply(1'b1, 32'hFFF00093); chk("addi_m1",    32'hFFFFFFFF, 3'd1, 1'b1, 1'b0);
    apply(1'b1, 32'h00822183); chk("lw_8",       32'h00000008, 3'd1, 1'b1, 1'b0);
    apply(1'b1, 32'h00322623); chk("sw_12",      32'h0000000C, 3'd2, 1'b1, 1'b0);
    apply(1'b1, 32'h0041D663); chk("bge_12",     32'h0000000C, 3'd3, 1'b1, 1'b0);
    apply(1'b1, 32'hFE000EE3); chk("beq_m4",     32'hFFFFFFFC, 3'd3, 1'b1, 1'b0);
    apply(1'b1, 32'h050001EF); chk("jal_80",     32'h00000050, 3'd5, 1'b1, 1'b0);
    apply(1'b1, 32'h00002537); chk("lui_2",      32'h00002000, 3'd4, 1'b1, 1'b0);
    apply(1'b1, 32'h4030D093); chk("srai_3",     32'h00000003, 3'd1, 1'b1, 1'b0);
    apply(1'b1, 32'hFFF00067); chk("jalr_m1",    32'hFFFFFFFF, 3'd1, 1'b1, 1'b0);
    apply(1'b1, 32'h002081B3); chk("add_rtype",  32'h00000000, 3'd0, 1'b1, 1'b0);
    apply(1'b1, 32'h00000000); chk("zero_instr", 32'h00000000, 3'd0, 1'b1, 1'b1);
    apply(1'b1, 32'h0000000F); chk("fence",      32'h00000000, 3'd0, 1'b1, 1'b0);
`ifdef IMM_ZICSR_EN
    apply(1'b1, 32'h3002D073); chk("csrrwi",     32'h00000005, 3'd6, 1'b1, 1'b0);
    apply(1'b1, 32'h30001073); chk("csrrw",      32'h00000300, 3'd1, 1'b1, 1'b0);
`else
    apply(1'b1, 32'h3002D073); chk("csrrwi",     32'h00000000, 3'd0, 1'b1, 1'b0);
    apply(1'b1, 32'h30001073); chk("csrrw",      32'h00000000, 3'd0, 1'b1, 1'b0);
`endif

    // Bubble: payload holds, valid drops
    apply(1'b1, 32'h00322623); chk("sw_again",   32'h0000000C, 3'd2, 1'b1, 1'b0);
    apply(1'b0, 32'h00000000); chk("hold_1",     32'h0000000C, 3'd2, 1'b0, 1'b0);
    apply(1'b0, 32'h050001EF); chk("hold_2",     32'h0000000C, 3'd2, 1'b0, 1'b0);

    // Asynchronous reset between clock edges
    apply(1'b1, 32'hFFF00093);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 32'h0, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_held", 32'h0, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    apply(1'b1, 32'h00410193); chk("after_rst",  32'h00000004, 3'd1, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
